// File: rtl/fp_divider_if.sv
// Start/done handshake bundle for the sequential floating-point divider.
//   start : request from the master, sampled by the divider only while idle
//   A, B  : dividend and divisor, captured on the accepted start edge
//   out   : quotient, held from a done pulse until the next one
//   done  : one-cycle pulse marking out as freshly valid
//   busy  : divider is working (cycle after accept through the done cycle)
// Parameter X selects binary32 (32) or binary64 (64) operands.
interface fp_divider_if #(
  parameter int X = 32
);
  logic         start;
  logic [X-1:0] A;
  logic [X-1:0] B;
  logic [X-1:0] out;
  logic         done;
  logic         busy;

  modport master (
    output start, A, B,
    input  out, done, busy
  );

  modport slave (
    input  start, A, B,
    output out, done, busy
  );
endinterface

// File: rtl/fp_divider.sv
// Sequential IEEE-754 divider, out = A / B, companion to the FPU multiplier.
// A radix-2 restoring mantissa divider is stepped by an FSM
// IDLE -> CHECK -> DIVIDE -> PACK -> IDLE, one quotient bit per cycle.
// Special operands (NaN, inf, zero, denormal-as-zero) resolve in CHECK.
// The result is truncated (round toward zero); overflow saturates to
// infinity and underflow flushes to signed zero.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything (aborts an op)
//   bus : fp_divider_if slave side (start, A, B in; out, done, busy out)
module fp_divider #(
  parameter int X = 32
) (
  input  logic     clk,
  input  logic     rst,
  fp_divider_if.slave bus
);

  localparam int EW = (X == 32) ? 8 : 11;
  localparam int MW = (X == 32) ? 23 : 52;
  localparam int CW = $clog2(MW + 2);

  localparam logic [EW-1:0]        EXP_ONES = '1;
  localparam logic signed [EW+1:0] BIAS_E   = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] E_ONE    = (EW+2)'(1);
  localparam logic signed [EW+1:0] E_ZERO   = '0;
  localparam logic [CW-1:0]        CNT_LAST = CW'(MW + 1);
  localparam logic [X-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIVIDE,
    PACK
  } state_t;

  state_t                 state, state_nxt;
  logic [X-1:0]           a_lat, a_nxt;
  logic [X-1:0]           b_lat, b_nxt;
  logic                   sign_r, sign_nxt;
  logic [MW+1:0]          r_lat, r_nxt;
  logic [MW:0]            d_lat, d_nxt;
  logic [MW+1:0]          q_lat, q_nxt;
  logic signed [EW+1:0]   e_lat, e_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [X-1:0]           out_r, out_nxt;
  logic                   done_r, done_nxt;

  // Operand field decode of the latched operands.
  logic [EW-1:0] exp_a, exp_b;
  logic [MW-1:0] mant_a, mant_b;
  logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic          sign_cur;
  logic [MW+1:0] d_ext, diff;

  assign exp_a    = a_lat[X-2:MW];
  assign exp_b    = b_lat[X-2:MW];
  assign mant_a   = a_lat[MW-1:0];
  assign mant_b   = b_lat[MW-1:0];
  // Denormals count as zero: only the exponent field is inspected.
  assign zero_a   = (exp_a == '0);
  assign zero_b   = (exp_b == '0);
  assign inf_a    = (exp_a == EXP_ONES) && (mant_a == '0);
  assign inf_b    = (exp_b == EXP_ONES) && (mant_b == '0);
  assign nan_a    = (exp_a == EXP_ONES) && (mant_a != '0);
  assign nan_b    = (exp_b == EXP_ONES) && (mant_b != '0);
  assign sign_cur = a_lat[X-1] ^ b_lat[X-1];
  assign d_ext    = {1'b0, d_lat};
  assign diff     = r_lat - d_ext;

  // Normalise the quotient (which lies in (0.5, 2)), truncate, and
  // saturate the exponent to infinity or flush it to zero.
  function automatic logic [X-1:0] pack_result(
    input logic                 sgn,
    input logic signed [EW+1:0] e_in,
    input logic [MW+1:0]        q_in
  );
    logic signed [EW+1:0] e_adj;
    logic [MW-1:0]        mant;
    if (q_in[MW+1]) begin
      mant  = q_in[MW:1];
      e_adj = e_in;
    end else begin
      mant  = q_in[MW-1:0];
      e_adj = e_in - E_ONE;
    end
    if (e_adj >= EXP_MAX)
      pack_result = {sgn, EXP_ONES, {MW{1'b0}}};
    else if (e_adj <= E_ZERO)
      pack_result = {sgn, {(X-1){1'b0}}};
    else
      pack_result = {sgn, e_adj[EW-1:0], mant};
  endfunction

  always_comb begin
    state_nxt = state;
    a_nxt     = a_lat;
    b_nxt     = b_lat;
    sign_nxt  = sign_r;
    r_nxt     = r_lat;
    d_nxt     = d_lat;
    q_nxt     = q_lat;
    e_nxt     = e_lat;
    cnt_nxt   = cnt;
    out_nxt   = out_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.A;
          b_nxt     = bus.B;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        sign_nxt = sign_cur;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
          out_nxt   = QNAN;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (inf_a || zero_b) begin
          out_nxt   = {sign_cur, EXP_ONES, {MW{1'b0}}};
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (zero_a || inf_b) begin
          out_nxt   = {sign_cur, {(X-1){1'b0}}};
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          r_nxt     = {2'b01, mant_a};
          d_nxt     = {1'b1, mant_b};
          q_nxt     = '0;
          cnt_nxt   = '0;
          e_nxt     = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_E;
          state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        // Remainder stays below D, so the shifted value fits in MW+2 bits.
        if (r_lat >= d_ext) begin
          q_nxt = {q_lat[MW:0], 1'b1};
          r_nxt = {diff[MW:0], 1'b0};
        end else begin
          q_nxt = {q_lat[MW:0], 1'b0};
          r_nxt = {r_lat[MW:0], 1'b0};
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CNT_LAST)
          state_nxt = PACK;
      end
      PACK: begin
        out_nxt   = pack_result(sign_r, e_lat, q_lat);
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_lat  <= '0;
      b_lat  <= '0;
      sign_r <= 1'b0;
      r_lat  <= '0;
      d_lat  <= '0;
      q_lat  <= '0;
      e_lat  <= '0;
      cnt    <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_lat  <= a_nxt;
      b_lat  <= b_nxt;
      sign_r <= sign_nxt;
      r_lat  <= r_nxt;
      d_lat  <= d_nxt;
      q_lat  <= q_nxt;
      e_lat  <= e_nxt;
      cnt    <= cnt_nxt;
      out_r  <= out_nxt;
      done_r <= done_nxt;
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;
  // The done cycle is already back in IDLE but still counts as busy.
  assign bus.busy = (state != IDLE) || done_r;

endmodule

// File: tb/tb_fp_divider.sv
// Testbench for fp_divider: table of binary32 vectors driven through a
// scoreboard queue, plus sequences for busy-ignore, back-to-back start,
// reset abort and one binary64 division.
module tb_fp_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_divider_if #(.X(32)) ifc ();
  fp_divider_if #(.X(64)) ifc64 ();

  fp_divider #(.X(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  fp_divider #(.X(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (ifc64.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp_out;
    int          exp_lat;
    int          n0;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[16];
  int   checks   = 0;
  int   failures = 0;
  int   ncnt     = 0;

  // Advance to the next falling edge and retire any result the DUT presents.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    ncnt++;
    if (ifc.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done out=%h required=no done pulse", ifc.out);
      end else begin
        e = sb.pop_front();
        checks++;
        if (ifc.out !== e.exp_out) begin
          failures++;
          $display("FAIL %s_out actual=%h required=%h", e.name, ifc.out, e.exp_out);
        end
        checks++;
        if ((ncnt - e.n0) != e.exp_lat) begin
          failures++;
          $display("FAIL %s_latency actual=%0d required=%0d", e.name, ncnt - e.n0, e.exp_lat);
        end
      end
    end
  endtask

  // Present one start pulse; an accepted request is queued on the scoreboard.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic accept, input logic [31:0] eo,
                       input int lat, input string nm);
    sb_t e;
    ifc.A     = a;
    ifc.B     = b;
    ifc.start = 1'b1;
    if (accept) begin
      e.name    = nm;
      e.exp_out = eo;
      e.exp_lat = lat;
      e.n0      = ncnt;
      sb.push_back(e);
    end
    tick();
    ifc.start = 1'b0;
    if (accept) begin
      checks++;
      if (ifc.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy actual=%b required=1", nm, ifc.busy);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int          n0_64;
    int          k;
    logic        seen;

    vecs[0]  = '{"div_6_2",      32'h40C00000, 32'h40000000, 32'h40400000, 28};
    vecs[1]  = '{"div_1_3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28};
    vecs[2]  = '{"div_1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 28};
    vecs[3]  = '{"neg1_by_0",    32'hBF800000, 32'h00000000, 32'hFF800000, 2};
    vecs[4]  = '{"zero_zero",    32'h00000000, 32'h00000000, 32'h7FC00000, 2};
    vecs[5]  = '{"inf_inf",      32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};
    vecs[6]  = '{"overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 28};
    vecs[7]  = '{"underflow",    32'h00800000, 32'h40000000, 32'h00000000, 28};
    vecs[8]  = '{"nan_a",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2};
    vecs[9]  = '{"fin_by_inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 2};
    vecs[10] = '{"neg_by_inf",   32'hC0000000, 32'h7F800000, 32'h80000000, 2};
    vecs[11] = '{"denorm_a",     32'h00000001, 32'h3F800000, 32'h00000000, 2};
    vecs[12] = '{"inf_by_neg",   32'h7F800000, 32'hC0000000, 32'hFF800000, 2};
    vecs[13] = '{"neg6_2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 28};
    vecs[14] = '{"pi_2",         32'h40490FDB, 32'h40000000, 32'h3FC90FDB, 28};
    vecs[15] = '{"three_4",      32'h40400000, 32'h40800000, 32'h3F400000, 28};

    rst         = 1'b1;
    ifc.start   = 1'b0;
    ifc.A       = '0;
    ifc.B       = '0;
    ifc64.start = 1'b0;
    ifc64.A     = '0;
    ifc64.B     = '0;
    repeat (3) tick();

    checks++;
    if (ifc.out !== 32'h0) begin failures++; $display("FAIL rst_out actual=%h required=0", ifc.out); end
    checks++;
    if (ifc.done !== 1'b0) begin failures++; $display("FAIL rst_done actual=%b required=0", ifc.done); end
    checks++;
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", ifc.busy); end
    checks++;
    if (ifc64.out !== 64'h0) begin failures++; $display("FAIL rst_out64 actual=%h required=0", ifc64.out); end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp_out, vecs[i].lat, vecs[i].name);
      wait_idle(60);
      tick();
    end

    // A start while busy must be dropped without disturbing the running op.
    drive(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 28, "busy_ign");
    repeat (5) tick();
    drive(32'h3F800000, 32'h40400000, 1'b0, 32'h0, 0, "ignored");
    wait_idle(60);
    repeat (35) tick();

    // Back-to-back: second start lands in the done cycle of the first.
    drive(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 28, "b2b_first");
    seen = 1'b0;
    k = 0;
    while (!seen && k < 60) begin
      tick();
      seen = (ifc.done === 1'b1);
      k++;
    end
    drive(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 28, "b2b_second");
    wait_idle(60);
    tick();

    // Reset ten cycles into a divide aborts it with no done pulse.
    drive(32'h40490FDB, 32'h40000000, 1'b0, 32'h0, 0, "abort");
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%b required=0", ifc.busy); end
    checks++;
    if (ifc.out !== 32'h0) begin failures++; $display("FAIL abort_out actual=%h required=0", ifc.out); end
    checks++;
    if (ifc.done !== 1'b0) begin failures++; $display("FAIL abort_done actual=%b required=0", ifc.done); end
    rst = 1'b0;
    repeat (40) tick();

    // binary64: 6.0 / 2.0 = 3.0 after 57 cycles.
    ifc64.A     = 64'h4018000000000000;
    ifc64.B     = 64'h4000000000000000;
    ifc64.start = 1'b1;
    n0_64       = ncnt;
    tick();
    ifc64.start = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      tick();
      seen = (ifc64.done === 1'b1);
      k++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL x64_done actual=none required=done within 100 cycles");
    end else begin
      checks++;
      if (ifc64.out !== 64'h4008000000000000) begin
        failures++;
        $display("FAIL x64_out actual=%h required=4008000000000000", ifc64.out);
      end
      checks++;
      if ((ncnt - n0_64) != 57) begin
        failures++;
        $display("FAIL x64_latency actual=%0d required=57", ncnt - n0_64);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
